// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder header/table loaders.
// State encoding and DQT-related constants.
package aq_djpeg_pkg;

  localparam int DQT_TABLE_SIZE = 64;
  localparam logic [7:0] MARKER_DQT = 8'hDB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN_H = 3'd1,
    ST_LEN_L = 3'd2,
    ST_PQTQ  = 3'd3,
    ST_TABLE = 3'd4,
    ST_FIN   = 3'd5
  } dqt_state_e;

endpackage

// File: rtl/aq_djpeg_dqt_ctrl.sv
// DQT segment parser: consumes Lq / Pq,Tq / table bytes and sequences
// writes into the two 64-entry quantization tables.
module aq_djpeg_dqt_ctrl
  import aq_djpeg_pkg::*;
#(
  parameter bit ALIAS_TQ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       DataInValid,
  input  logic [7:0] DataIn,
  output logic       DataInReady,
  output logic       DqtEnable,
  output logic       DqtColor,
  output logic [5:0] DqtCount,
  output logic [7:0] DqtData,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [1:0] TableLoaded
);

  // Handshake: a byte moves when DataInValid & DataInReady at a rising edge.
  // DataInReady depends on state only, never on DataInValid.

  dqt_state_e state, stateNext;

  logic [7:0]  lenHi;
  logic [15:0] remaining;
  logic [5:0]  index;
  logic        color;
  logic        suppress;
  logic        setErr;

  logic        xfer;
  logic [15:0] lqFull;
  logic [15:0] remDec;
  logic        lastIdx;
  logic        pqBad;
  logic        tqBad;

  assign DataInReady = (state == ST_LEN_H) || (state == ST_LEN_L) ||
                       (state == ST_PQTQ)  || (state == ST_TABLE);
  assign Busy    = (state != ST_IDLE);
  assign xfer    = DataInValid & DataInReady;
  assign lqFull  = {lenHi, DataIn};
  assign remDec  = remaining - 16'd1;
  assign lastIdx = (index == 6'(DQT_TABLE_SIZE - 1));
  assign pqBad   = (DataIn[7:4] != 4'd0);
  assign tqBad   = (DataIn[3:0] > 4'd1) && !ALIAS_TQ;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    setErr    = 1'b0;
    case (state)
      ST_IDLE:  if (Start) stateNext = ST_LEN_H;
      ST_LEN_H: if (xfer) stateNext = ST_LEN_L;
      ST_LEN_L: begin
        if (xfer) begin
          if (lqFull < 16'd2) begin
            setErr    = 1'b1;
            stateNext = ST_FIN;
          end else if (lqFull == 16'd2) begin
            stateNext = ST_FIN;
          end else begin
            stateNext = ST_PQTQ;
          end
        end
      end
      ST_PQTQ: begin
        if (xfer) begin
          // A Pq/Tq byte with no table bytes behind it is a truncated segment.
          if (pqBad || remDec == 16'd0) begin
            setErr    = 1'b1;
            stateNext = ST_FIN;
          end else begin
            setErr    = tqBad;
            stateNext = ST_TABLE;
          end
        end
      end
      ST_TABLE: begin
        if (xfer) begin
          if (lastIdx) begin
            stateNext = (remDec == 16'd0) ? ST_FIN : ST_PQTQ;
          end else if (remDec == 16'd0) begin
            setErr    = 1'b1;
            stateNext = ST_FIN;
          end
        end
      end
      ST_FIN:  stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lenHi       <= 8'd0;
      remaining   <= 16'd0;
      index       <= 6'd0;
      color       <= 1'b0;
      suppress    <= 1'b0;
      DqtEnable   <= 1'b0;
      DqtColor    <= 1'b0;
      DqtCount    <= 6'd0;
      DqtData     <= 8'd0;
      Done        <= 1'b0;
      Error       <= 1'b0;
      TableLoaded <= 2'b00;
    end else begin
      DqtEnable <= 1'b0;
      // Registered so Done always trails the final write by a cycle.
      Done      <= (state == ST_FIN);
      if (state == ST_IDLE && Start) Error <= 1'b0;
      else if (setErr)               Error <= 1'b1;

      case (state)
        ST_LEN_H: if (xfer) lenHi <= DataIn;
        ST_LEN_L: if (xfer) remaining <= lqFull - 16'd2;
        ST_PQTQ: begin
          if (xfer) begin
            remaining <= remDec;
            index     <= 6'd0;
            suppress  <= tqBad;
            color     <= DataIn[0];
          end
        end
        ST_TABLE: begin
          if (xfer) begin
            remaining <= remDec;
            index     <= index + 6'd1;
            DqtEnable <= !suppress;
            DqtCount  <= index;
            DqtData   <= DataIn;
            DqtColor  <= color;
            if (lastIdx && !suppress) TableLoaded[color] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_djpeg_dqt_ctrl.sv
// Bench for aq_djpeg_dqt_ctrl: segment vectors from a table, write stream
// checked against an expected queue, plus reset-abort and busy-Start cases.
module tb_aq_djpeg_dqt_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Start = 1'b0;
  logic       DataInValid = 1'b0;
  logic [7:0] DataIn = 8'd0;
  logic       DataInReady;
  logic       DqtEnable;
  logic       DqtColor;
  logic [5:0] DqtCount;
  logic [7:0] DqtData;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic [1:0] TableLoaded;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [14:0] exp_q[$];

  typedef struct {
    logic [15:0] lq;
    logic [15:0] pqtq;      // [7:0] first table, [15:8] second table
    int          nsend;     // body bytes driven after Lq
    bit          toggle;    // idle cycle between body bytes
    bit          rnd;       // random data, else data = index + 1
    logic [1:0]  wen;       // per table: writes expected
    logic [1:0]  color;     // per table: expected DqtColor
    int          start_at;  // body byte before which Start is pulsed, -1 none
    bit          exp_err;
    logic [1:0]  exp_loaded;
  } vec_t;

  vec_t vecs[9];

  aq_djpeg_dqt_ctrl #(.ALIAS_TQ(1'b0)) dut (
    .clk(clk), .rst(rst), .Start(Start), .DataInValid(DataInValid),
    .DataIn(DataIn), .DataInReady(DataInReady), .DqtEnable(DqtEnable),
    .DqtColor(DqtColor), .DqtCount(DqtCount), .DqtData(DqtData),
    .Busy(Busy), .Done(Done), .Error(Error), .TableLoaded(TableLoaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write is popped from the expected queue.
  always @(negedge clk) begin
    if (Done) done_cnt++;
    if (Done && DqtEnable) begin
      total++; bad++;
      $display("FAIL done_with_write at %0t", $time);
    end
    if (DqtEnable) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=%0h", {DqtColor, DqtCount, DqtData});
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        if ({DqtColor, DqtCount, DqtData} !== e) begin
          bad++;
          $display("FAIL write actual=%0h expected=%0h", {DqtColor, DqtCount, DqtData}, e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    DataIn = b;
    DataInValid = 1'b1;
    while (!DataInReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'(DataInReady), 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      DataInValid = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    DataInValid = 1'b0;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int done0;
    int guard;
    int blk;
    int pos;
    logic [7:0] b;
    done0 = done_cnt;
    pulse_start();
    chk($sformatf("v%0d_busy", id), 32'(Busy), 32'd1);
    chk($sformatf("v%0d_err_clr", id), 32'(Error), 32'd0);
    send_byte(v.lq[15:8]);
    send_byte(v.lq[7:0]);
    for (int k = 0; k < v.nsend; k++) begin
      if (k == v.start_at) pulse_start();
      blk = k / 65;
      pos = k % 65;
      if (pos == 0) begin
        b = v.pqtq[blk*8 +: 8];
      end else begin
        b = v.rnd ? 8'($urandom_range(0, 255)) : 8'(pos);
        if (v.wen[blk]) exp_q.push_back({v.color[blk], 6'(pos - 1), b});
      end
      if (v.toggle && k > 0) idle(1);
      send_byte(b);
    end
    @(negedge clk);
    DataInValid = 1'b0;
    guard = 0;
    while (done_cnt == done0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("v%0d_done_seen", id), 32'(done_cnt != done0), 32'd1);
    idle(3);
    chk($sformatf("v%0d_done_once", id), 32'(done_cnt - done0), 32'd1);
    chk($sformatf("v%0d_writes_left", id), 32'(exp_q.size()), 32'd0);
    chk($sformatf("v%0d_error", id), 32'(Error), 32'(v.exp_err));
    chk($sformatf("v%0d_loaded", id), 32'(TableLoaded), 32'(v.exp_loaded));
    chk($sformatf("v%0d_ready_idle", id), 32'(DataInReady), 32'd0);
    chk($sformatf("v%0d_busy_idle", id), 32'(Busy), 32'd0);
    exp_q.delete();
  endtask

  function automatic vec_t mk(input logic [15:0] lq, input logic [15:0] pqtq,
                              input int nsend, input bit toggle, input bit rnd,
                              input logic [1:0] wen, input logic [1:0] color,
                              input int start_at, input bit exp_err,
                              input logic [1:0] exp_loaded);
    vec_t v;
    v.lq = lq; v.pqtq = pqtq; v.nsend = nsend; v.toggle = toggle; v.rnd = rnd;
    v.wen = wen; v.color = color; v.start_at = start_at;
    v.exp_err = exp_err; v.exp_loaded = exp_loaded;
    return v;
  endfunction

  initial begin
    // Short segment: 45 table bytes, error, nothing marked loaded.
    vecs[0] = mk(16'h0030, 16'h0000, 46, 0, 0, 2'b01, 2'b00, -1, 1, 2'b00);
    // Tq=2 with aliasing off: bytes consumed, no writes.
    vecs[1] = mk(16'h0043, 16'h0002, 65, 0, 1, 2'b00, 2'b00, -1, 1, 2'b00);
    // Pq=1: error right after the Pq/Tq byte.
    vecs[2] = mk(16'h0043, 16'h0010, 1, 0, 0, 2'b00, 2'b00, -1, 1, 2'b00);
    // Empty segment and too-short Lq.
    vecs[3] = mk(16'h0002, 16'h0000, 0, 0, 0, 2'b00, 2'b00, -1, 0, 2'b00);
    vecs[4] = mk(16'h0001, 16'h0000, 0, 0, 0, 2'b00, 2'b00, -1, 1, 2'b00);
    // Full Y table, data 1..64.
    vecs[5] = mk(16'h0043, 16'h0000, 65, 0, 0, 2'b01, 2'b00, -1, 0, 2'b01);
    // Y then C in one segment with gaps between bytes.
    vecs[6] = mk(16'h0084, 16'h0100, 130, 1, 1, 2'b11, 2'b10, -1, 0, 2'b11);
    // Tq=3 error, then overwrite of C table.
    vecs[7] = mk(16'h0043, 16'h0003, 65, 0, 1, 2'b00, 2'b00, -1, 1, 2'b11);
    vecs[8] = mk(16'h0043, 16'h0001, 65, 0, 1, 2'b01, 2'b01, -1, 0, 2'b11);

    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(DqtEnable), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(DataInReady), 32'd0);
    chk("rst_loaded", 32'(TableLoaded), 32'd0);
    chk("rst_count", 32'({DqtColor, DqtCount, DqtData}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while writing table entry 20.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h43);
    send_byte(8'h00);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      exp_q.push_back({1'b0, 6'(i), d});
      send_byte(d);
    end
    @(negedge clk);
    DataIn = 8'h55;
    DataInValid = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_enable", 32'(DqtEnable), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_ready", 32'(DataInReady), 32'd0);
    chk("abort_loaded", 32'(TableLoaded), 32'd0);
    chk("abort_count", 32'({DqtCount, DqtData}), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_writes_left", 32'(exp_q.size()), 32'd0);
    DataInValid = 1'b0;
    rst = 1'b1;
    exp_q.delete();

    // Fresh C table after reset, with a Start pulse mid-table that must be ignored.
    run_vec(mk(16'h0043, 16'h0001, 65, 0, 1, 2'b01, 2'b01, 30, 0, 2'b10), 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
